mac_array_4x4_core: RTL and testbench
=====================================

// Module: mac_array_4x4_core
// PURPOSE
//  Signed int8 4x4 matrix-multiply accelerator: C = A x B with 32-bit accumulators.
//  A and B are written element by element; a start pulse computes all 16 dot products, N MACs each.
//  C is then read back by address.
//  Leaf compute block behind a host/bus write-read port; no internal memory interface.
// PARAMETERS
//  N       4   matrix dimension (addresses assume N=4, 4-bit linear index)
//  DATA_W  8   signed element width of A and B
//  MUL_W   16  signed product width (2*DATA_W)
//  ACC_W   32  signed accumulator / result width
// PORTS
//  clock      in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-high reset
//  load_A     in   1       write strobe for A
//  a_addr     in   4       A index = row*4+col
//  a_wdata    in   DATA_W  signed A element
//  load_B     in   1       write strobe for B
//  b_addr     in   4       B index = row*4+col
//  b_wdata    in   DATA_W  signed B element
//  start      in   1       1-cycle pulse, begin compute
//  done       out  1       level, high while result is complete (DONE state)
//  out_valid  out  1       C contents hold a completed result
//  out_addr   in   4       C read index = row*4+col
//  out_rdata  out  ACC_W   signed C[out_addr]
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, done=0, out_valid=0, k=0, all C=0.
//    A and B are also cleared to 0. Reset wins over every other input in that cycle.
//  - Loads: load_A=1 at posedge -> A[a_addr]<=a_wdata; same for B; both may occur together.
//    Loads are accepted in IDLE and DONE. They are ignored in CLEAR and COMPUTE.
//    A load in DONE does not alter C, done or out_valid.
//  - FSM IDLE -> CLEAR -> COMPUTE -> DONE:
//    IDLE/DONE + start=1: go CLEAR; done<=0, out_valid<=0.
//    CLEAR: all C<=0, k<=0 (one cycle).
//    COMPUTE: every cycle, all 16 cells do C[i][j] += sext(A[i][k]*B[k][j]); k++.
//      After k=N-1 go DONE.
//    DONE: done=1, out_valid=1; hold until next start or reset.
//  - Latency: start sampled at edge T -> done high after edge T+N+1 (T+5). Must be well under 100 cycles.
//  - start outside IDLE/DONE is ignored; no restart mid-compute.
//  - Arithmetic: signed DATA_W x DATA_W -> MUL_W product, sign-extended to ACC_W.
//    Two's-complement add wraps.
//    -128*-128 = +16384 must be correct.
//  - Read: out_rdata = C[out_addr], combinational from registers, valid same cycle.
//    Reads in any state return current C (0 after reset).
// CONFIGURATION
//  MAC_SAT_EN defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//  MAC_SAT_EN undefined: accumulate wraps modulo 2^ACC_W.
//  No difference at default widths; only observable with reduced ACC_W.
// TESTING
//  1 A=0, B=0, start -> done within 100 cycles; all 16 C = 0.
//  2 A=identity, B=random int8 -> C == B (sign-extended), out_valid=1.
//  3 A=all 127, B=all 1 -> every C = 508.
//    A=all -128, B=all 1 -> every C = -512.
//    A=all -128, B=all -128 -> every C = 65536.
//  4 A[i][j]=(i+j) odd?10:-10, B[i][j]=(i*j) odd?5:-5 -> C[i][j]=0 for j even.
//    For j odd: C = +200 when i even, -200 when i odd.
//  5 Random A,B x5 vs golden sum_k A[i][k]*B[k][j] -> zero mismatches.
//    Also: start pulsed again mid-COMPUTE is ignored (result unchanged, done at T+5).
//  6 reset=1 during COMPUTE -> next cycle done=0, out_valid=0, all C=0, state IDLE.
//    A new load+start then computes correctly.

Source files
------------

// File: rtl/mac_array_4x4_core_if.sv
// rtl/mac_array_4x4_core_if.sv - host write/read port bundle for the 4x4 int8 MAC array
interface mac_array_4x4_core_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                     load_A;
    logic [3:0]               a_addr;
    logic signed [DATA_W-1:0] a_wdata;
    logic                     load_B;
    logic [3:0]               b_addr;
    logic signed [DATA_W-1:0] b_wdata;
    logic                     start;
    logic                     done;
    logic                     out_valid;
    logic [3:0]               out_addr;
    logic signed [ACC_W-1:0]  out_rdata;

    modport master (
        output load_A, a_addr, a_wdata, load_B, b_addr, b_wdata, start, out_addr,
        input  done, out_valid, out_rdata
    );

    modport slave (
        input  load_A, a_addr, a_wdata, load_B, b_addr, b_wdata, start, out_addr,
        output done, out_valid, out_rdata
    );
endinterface

// File: rtl/mac_array_4x4_core.sv
// rtl/mac_array_4x4_core.sv - signed int8 4x4 matmul C = A x B, 16 parallel MACs over N cycles
// Optional: define MAC_SAT_EN to saturate each accumulate instead of wrapping.
module mac_array_4x4_core #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int MUL_W  = 16,
    parameter int ACC_W  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    mac_array_4x4_core_if.slave  bus
);
    localparam int K_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     done_q, done_d;
    logic                     out_valid_q, out_valid_d;
    logic [K_W-1:0]           k_q, k_d;
    logic signed [DATA_W-1:0] a_q [N*N];
    logic signed [DATA_W-1:0] a_d [N*N];
    logic signed [DATA_W-1:0] b_q [N*N];
    logic signed [DATA_W-1:0] b_d [N*N];
    logic signed [ACC_W-1:0]  c_q [N*N];
    logic signed [ACC_W-1:0]  c_d [N*N];

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [MUL_W-1:0] p;
`ifdef MAC_SAT_EN
        logic signed [ACC_W:0] s;
        p = a * b;
        s = {acc[ACC_W-1], acc} + {{(ACC_W+1-MUL_W){p[MUL_W-1]}}, p};
        // Extra top bit disagreeing with the sign bit means the add left the ACC_W range
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
`else
        p = a * b;
        return acc + {{(ACC_W-MUL_W){p[MUL_W-1]}}, p};
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        out_valid_d = out_valid_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;

        if (state_q == IDLE || state_q == DONE) begin
            if (bus.load_A) a_d[bus.a_addr] = bus.a_wdata;
            if (bus.load_B) b_d[bus.b_addr] = bus.b_wdata;
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = CLEAR;
                    done_d      = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            CLEAR: begin
                for (int i = 0; i < N*N; i++) c_d[i] = '0;
                k_d     = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                // k selects column k of A and row k of B for every cell this cycle
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        c_d[i*N+j] = mac(c_q[i*N+j], a_q[i*N+int'(k_q)], b_q[int'(k_q)*N+j]);
                    end
                end
                k_d = k_q + K_W'(1);
                if (k_q == K_W'(N-1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            k_q         <= '0;
            for (int i = 0; i < N*N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rdata = c_q[bus.out_addr];
endmodule

// File: tb/tb_mac_array_4x4_core.sv
// tb/tb_mac_array_4x4_core.sv - scoreboard bench for mac_array_4x4_core
module tb_mac_array_4x4_core;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mac_array_4x4_core_if #(.DATA_W(8), .ACC_W(32)) bus ();

    mac_array_4x4_core #(.N(4), .DATA_W(8), .MUL_W(16), .ACC_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic rd_req = 1'b0;
    int ma [16];
    int mb [16];
    typedef struct { int idx; int val; } exp_t;
    exp_t exp_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every cycle a read is presented, pop the queued expectation and compare
    initial begin
        forever begin
            @(negedge clock);
            if (rd_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL c_read: unexpected read, got %0d expected none", bus.out_rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.out_addr != 4'(e.idx) || bus.out_rdata != e.val) begin
                        errors++;
                        $display("FAIL c_read[%0d]: got %0d expected %0d", e.idx, bus.out_rdata, e.val);
                    end
                end
            end
        end
    end

    task automatic read_c(input int exp_vals [16]);
        for (int a = 0; a < 16; a++) begin
            @(posedge clock); #1;
            bus.out_addr = 4'(a);
            rd_req = 1'b1;
            exp_q.push_back('{idx: a, val: exp_vals[a]});
        end
        @(posedge clock); #1;
        rd_req = 1'b0;
    endtask

    task automatic load_mats();
        for (int a = 0; a < 16; a++) begin
            @(posedge clock); #1;
            bus.load_A  = 1'b1; bus.a_addr = 4'(a); bus.a_wdata = 8'(ma[a]);
            bus.load_B  = 1'b1; bus.b_addr = 4'(a); bus.b_wdata = 8'(mb[a]);
        end
        @(posedge clock); #1;
        bus.load_A = 1'b0;
        bus.load_B = 1'b0;
    endtask

    task automatic run(input string name, input bit mid_start);
        int lat;
        lat = -1;
        @(posedge clock); #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clock); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (mid_start && c == 1) bus.start = 1'b1;
        end
        chk({name, "_latency"}, lat, 5);
        chk({name, "_out_valid"}, bus.out_valid, 1);
    endtask

    function automatic void golden(output int c [16]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c[i*4+j] = 0;
                for (int k = 0; k < 4; k++) c[i*4+j] += ma[i*4+k] * mb[k*4+j];
            end
    endfunction

    function automatic int rnd8();
        logic signed [7:0] v;
        v = 8'($urandom_range(0, 255));
        return int'(v);
    endfunction

    int ev [16];
    int bvals [16] = '{-128, 127, -1, 0, 1, 55, -77, 100, -100, 3, -3, 64, -64, 17, -17, 42};

    initial begin
        bus.load_A = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.load_B = 0; bus.b_addr = 0; bus.b_wdata = 0;
        bus.start = 0; bus.out_addr = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        chk("reset_done", bus.done, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        ev = '{default: 0};
        read_c(ev);

        // 1: zeros
        for (int a = 0; a < 16; a++) begin ma[a] = 0; mb[a] = 0; end
        load_mats();
        run("zero", 0);
        read_c(ev);

        // 2: identity x B gives B back; a load in DONE leaves C and flags alone
        for (int a = 0; a < 16; a++) begin ma[a] = (a % 5 == 0) ? 1 : 0; mb[a] = bvals[a]; end
        load_mats();
        run("ident", 0);
        read_c(bvals);
        @(posedge clock); #1;
        bus.load_A = 1; bus.a_addr = 0; bus.a_wdata = 8'sd99;
        @(posedge clock); #1;
        bus.load_A = 0;
        chk("done_after_load", bus.done, 1);
        chk("valid_after_load", bus.out_valid, 1);
        read_c(bvals);

        // 3: extremes
        for (int a = 0; a < 16; a++) begin ma[a] = 127; mb[a] = 1; end
        load_mats(); run("max_pos", 0);
        ev = '{default: 508}; read_c(ev);
        for (int a = 0; a < 16; a++) begin ma[a] = -128; mb[a] = 1; end
        load_mats(); run("max_neg", 0);
        ev = '{default: -512}; read_c(ev);
        for (int a = 0; a < 16; a++) begin ma[a] = -128; mb[a] = -128; end
        load_mats(); run("neg_sq", 0);
        ev = '{default: 65536}; read_c(ev);

        // 4: checkerboard signs
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i*4+j] = ((i + j) % 2 == 1) ? 10 : -10;
                mb[i*4+j] = ((i * j) % 2 == 1) ? 5 : -5;
                ev[i*4+j] = (j % 2 == 0) ? 0 : ((i % 2 == 0) ? 200 : -200);
            end
        load_mats(); run("pattern", 0);
        read_c(ev);

        // 5: random vs golden, last one with a second start mid-COMPUTE
        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < 16; a++) begin ma[a] = rnd8(); mb[a] = rnd8(); end
            load_mats();
            run("random", r == 4);
            golden(ev);
            read_c(ev);
        end

        // 6: reset mid-COMPUTE clears everything, then a fresh run works
        for (int a = 0; a < 16; a++) begin ma[a] = rnd8(); mb[a] = rnd8(); end
        load_mats();
        @(posedge clock); #1 bus.start = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_valid", bus.out_valid, 0);
        ev = '{default: 0};
        read_c(ev);
        run("after_rst_zero", 0);
        read_c(ev);
        load_mats();
        run("after_rst", 0);
        golden(ev);
        read_c(ev);

        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
